// File: rtl/rv_inst_encoder_if.sv
// rv_inst_encoder_if: request and encoded-word stream bundle for rv_inst_encoder
interface rv_inst_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;
    modport master (
        output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err, err_cnt
    );
    modport slave (
        input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, err, err_cnt
    );
endinterface

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: packs decoded RV32I descriptions into instruction words queued with load addresses
module rv_inst_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic              clk,
    input logic              rst,
    rv_inst_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifoState_e;
    fifoState_e        state, stateNext;
    logic [31:0]       imm;
    logic [31:0]       word;
    logic              legal, isShift;
    logic              fitsI, fitsB, fitsJ, fitsSh, fitsU;
    logic [31:0]       memInst [DEPTH];
    logic [ADDR_W-1:0] memAddr [DEPTH];
    logic [PW-1:0]     wrPtr, rdPtr, rdNext;
    logic [PW:0]       cnt, cntNext;
    logic [ADDR_W-1:0] addrCnt, outAddr;
    logic [31:0]       outInst;
    logic              accept, push, pop, headEmpty;
    logic              inReady, outValid, errQ;
    logic [7:0]        errCnt;
    assign imm     = bus.in_imm;
    assign isShift = bus.in_funct3[1:0] == 2'b01;
    // Range checks are sign-extension tests on the full 32-bit immediate
    assign fitsI   = &imm[31:11] | ~|imm[31:11];
    assign fitsB   = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
    assign fitsJ   = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];
    assign fitsSh  = ~|imm[31:5];
    assign fitsU   = ~|imm[11:0];
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (bus.in_class)
            4'd0: begin
                word  = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011};
                legal = 1'b1;
            end
            4'd1: begin
                word  = isShift ? {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011}
                                : {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
                legal = isShift ? fitsSh : fitsI;
            end
            4'd2: begin
                word  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], 7'b1100011};
                legal = fitsB;
            end
            4'd3: begin
                word  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b1100111};
                legal = fitsI;
            end
            4'd4: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
                legal = fitsJ;
            end
            4'd5: begin
                word  = {imm[31:12], bus.in_rd, 7'b0010111};
                legal = fitsU;
            end
            4'd6: begin
                word  = {imm[31:12], bus.in_rd, 7'b0110111};
                legal = fitsU;
            end
            4'd7: begin
                word  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011};
                legal = fitsI;
            end
            4'd8: begin
                word  = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], 7'b0100011};
                legal = fitsI;
            end
            4'd9: begin
                word  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b1110011};
                legal = fitsI;
            end
            default: ;
        endcase
    end
    assign accept    = bus.in_valid && inReady;
    assign push      = accept && legal;
    assign pop       = outValid && bus.out_ready;
    // Queue empty after this cycle's pop: the incoming word becomes the new head
    assign headEmpty = cnt == (PW+1)'(pop);
    always_comb begin
        stateNext = state;
        cntNext   = cnt + (PW+1)'(push) - (PW+1)'(pop);
        rdNext    = rdPtr + PW'(pop);
        case (state)
            EMPTY:   stateNext = push ? PARTIAL : EMPTY;
            PARTIAL: stateNext = (push && !pop && cnt == (PW+1)'(DEPTH - 1)) ? FULL
                               : (pop && !push && cnt == (PW+1)'(1)) ? EMPTY : PARTIAL;
            FULL:    stateNext = pop ? PARTIAL : FULL;
            default: stateNext = EMPTY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= stateNext;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            addrCnt  <= BASE_ADDR;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            outInst  <= '0;
            outAddr  <= '0;
            errQ     <= 1'b0;
            errCnt   <= '0;
        end else begin
            cnt      <= cntNext;
            rdPtr    <= rdNext;
            inReady  <= stateNext != FULL;
            outValid <= stateNext != EMPTY;
            errQ     <= accept && !legal;
            if (accept && !legal && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
            if (push) begin
                wrPtr   <= wrPtr + PW'(1);
                addrCnt <= addrCnt + ADDR_W'(4);
            end
            if (cntNext != '0) begin
                outInst <= headEmpty ? word : memInst[rdNext];
                outAddr <= headEmpty ? addrCnt : memAddr[rdNext];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            memInst[wrPtr] <= word;
            memAddr[wrPtr] <= addrCnt;
        end
    end
    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_inst  = outInst;
    assign bus.out_addr  = outAddr;
    assign bus.err       = errQ;
    assign bus.err_cnt   = errCnt;
endmodule

// File: tb/tb_rv_inst_encoder.sv
// tb_rv_inst_encoder: directed vector table plus backpressure, reset, saturation and wrap sequences
module tb_rv_inst_encoder;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    rv_inst_encoder_if #(.ADDR_W(32)) bus ();
    rv_inst_encoder_if #(.ADDR_W(4))  bus4 ();
    rv_inst_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    rv_inst_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ok;
        logic [31:0] inst;
    } vec_t;
    vec_t vecs [25];
    function automatic vec_t mk(input logic [3:0] cls, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm, input logic ok, input logic [31:0] inst);
        vec_t v;
        v.cls = cls; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7; v.imm = imm; v.ok = ok; v.inst = inst;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        bus.in_class = v.cls; bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
        bus.in_funct3 = v.f3; bus.in_funct7 = v.f7; bus.in_imm = v.imm;
    endtask
    task automatic addi(input int k);
        drive(mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), 1'b1, 32'h0));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [31:0] expAddr;
        logic [3:0]  a4;
        int          errExp;
        vecs[0]  = mk(4'd0,  5'd3,  5'd1,  5'd2, 3'd0, 7'h00, 32'h00000000, 1'b1, 32'h002081B3);
        vecs[1]  = mk(4'd1,  5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
        vecs[2]  = mk(4'd2,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3);
        vecs[3]  = mk(4'd4,  5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00000008, 1'b1, 32'h008000EF);
        vecs[4]  = mk(4'd8,  5'd31, 5'd1,  5'd2, 3'd2, 7'h00, 32'h00000008, 1'b1, 32'h0020A423);
        vecs[5]  = mk(4'd6,  5'd5,  5'd31, 5'd0, 3'd7, 7'h00, 32'h12345000, 1'b1, 32'h123452B7);
        vecs[6]  = mk(4'd1,  5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00000800, 1'b0, 32'h0);
        vecs[7]  = mk(4'd2,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00000003, 1'b0, 32'h0);
        vecs[8]  = mk(4'd6,  5'd5,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00001001, 1'b0, 32'h0);
        vecs[9]  = mk(4'd12, 5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 32'h0);
        vecs[10] = mk(4'd1,  5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h000007FF, 1'b1, 32'h7FF00093);
        vecs[11] = mk(4'd1,  5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFFF800, 1'b1, 32'h80000093);
        vecs[12] = mk(4'd1,  5'd1,  5'd1,  5'd0, 3'd1, 7'h00, 32'h0000001F, 1'b1, 32'h01F09093);
        vecs[13] = mk(4'd1,  5'd2,  5'd2,  5'd0, 3'd5, 7'h20, 32'h00000020, 1'b0, 32'h0);
        vecs[14] = mk(4'd1,  5'd2,  5'd2,  5'd0, 3'd5, 7'h20, 32'h00000003, 1'b1, 32'h40315113);
        vecs[15] = mk(4'd2,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00000FFE, 1'b1, 32'h7E000FE3);
        vecs[16] = mk(4'd2,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00001000, 1'b0, 32'h0);
        vecs[17] = mk(4'd4,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFF00000, 1'b1, 32'h8000006F);
        vecs[18] = mk(4'd4,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00100000, 1'b0, 32'h0);
        vecs[19] = mk(4'd3,  5'd1,  5'd5,  5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1, 32'h000280E7);
        vecs[20] = mk(4'd9,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00000000, 1'b1, 32'h00000073);
        vecs[21] = mk(4'd5,  5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b1, 32'hFFFFF097);
        vecs[22] = mk(4'd7,  5'd3,  5'd2,  5'd0, 3'd2, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFFC12183);
        vecs[23] = mk(4'd8,  5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFFF7FF, 1'b0, 32'h0);
        vecs[24] = mk(4'd10, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h00000000, 1'b0, 32'h0);
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
        drive(vecs[0]);
        bus4.in_class = 4'd1; bus4.in_rd = 5'd1; bus4.in_rs1 = 5'd0; bus4.in_rs2 = 5'd0;
        bus4.in_funct3 = 3'd0; bus4.in_funct7 = 7'd0; bus4.in_imm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst = 1'b0;
        expAddr = 32'h0;
        errExp = 0;
        for (int i = 0; i < 25; i++) begin
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            drive(vecs[i]);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (vecs[i].ok) begin
                chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
                chk($sformatf("v%0d_inst", i), bus.out_inst, vecs[i].inst);
                chk($sformatf("v%0d_addr", i), bus.out_addr, expAddr);
                chk($sformatf("v%0d_err", i), 32'(bus.err), 32'd0);
                expAddr += 32'd4;
            end else begin
                chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd0);
                chk($sformatf("v%0d_err", i), 32'(bus.err), 32'd1);
                errExp++;
            end
            chk($sformatf("v%0d_err_cnt", i), 32'(bus.err_cnt), 32'(errExp));
            @(posedge clk); #1;
            chk($sformatf("v%0d_err_after", i), 32'(bus.err), 32'd0);
            chk($sformatf("v%0d_drained", i), 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addi(k);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("rq_valid", 32'(bus.out_valid), 32'd1);
        addi(9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rq_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rq_err_cnt", 32'(bus.err_cnt), 32'd0);
        chk("rq_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("rq_no_accept", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        addi(7);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rq_next_valid", 32'(bus.out_valid), 32'd1);
        chk("rq_next_inst", bus.out_inst, 32'h00700093);
        chk("rq_next_addr", bus.out_addr, 32'h0);
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addi(k);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_head_inst", bus.out_inst, 32'h00000093);
        addi(4);
        @(posedge clk); #1;
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_inst", bus.out_inst, 32'h00000093);
        chk("bp_hold_addr", bus.out_addr, 32'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.in_valid = 1'b0;
            chk($sformatf("bp%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_inst", i), bus.out_inst, 32'h00000093 | (32'(i) << 20));
            chk($sformatf("bp%0d_addr", i), bus.out_addr, 32'(i) * 32'd4);
            if (i == 1) chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        chk("bp_empty", 32'(bus.out_valid), 32'd0);
        bus.in_class = 4'd12;
        bus.in_valid = 1'b1;
        repeat (254) @(posedge clk);
        #1;
        chk("sat_254", 32'(bus.err_cnt), 32'd254);
        repeat (46) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("sat_err", 32'(bus.err), 32'd1);
        chk("sat_cnt", 32'(bus.err_cnt), 32'd255);
        chk("sat_nothing", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("sat_err_low", 32'(bus.err), 32'd0);
        chk("sat_hold", 32'(bus.err_cnt), 32'd255);
        bus4.in_valid = 1'b1;
        a4 = 4'h0;
        for (int k = 0; k < 5; k++) begin
            bus4.in_imm = 32'(k);
            @(posedge clk); #1;
            if (k == 4) bus4.in_valid = 1'b0;
            chk($sformatf("w%0d_valid", k), 32'(bus4.out_valid), 32'd1);
            chk($sformatf("w%0d_inst", k), bus4.out_inst, 32'h00000093 | (32'(k) << 20));
            chk($sformatf("w%0d_addr", k), 32'(bus4.out_addr), 32'(a4));
            a4 = a4 + 4'd4;
        end
        @(posedge clk); #1;
        chk("w_empty", 32'(bus4.out_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
